// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment counter: active-low segment codes,
// the blank code and the per-radix digit maxima.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] DIG_MAX_DEC = 4'd9;
    localparam logic [3:0] DIG_MAX_HEX = 4'hF;

    // In decimal mode any nibble above 9 is held at 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] dig, input logic dec);
        logic [3:0] res;
        if (dec && (dig > DIG_MAX_DEC)) begin
            res = DIG_MAX_DEC;
        end else begin
            res = dig;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low seven-segment code (bit 7 = DP, always off).
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] seg_o
);

    // Segment lookup for one digit.
    always_comb begin
        seg_o = SEG_BLANK;
        case (nib_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_counter_display.sv
// Multi-digit up/down BCD/hex counter with prescaler, wrap pulse and a
// registered seven-segment display with optional leading-zero blanking.
module seg_counter_display
    import seg_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  mode_dec,
    input  logic                  blank_lz,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [8*DIGITS-1:0]   hex
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic [8*DIGITS-1:0]   hex_q, hex_d;

    logic                  tick_s;
    logic [3:0]            dig_max_s;
    logic [4*DIGITS-1:0]   clamped_s;
    logic [4*DIGITS-1:0]   load_clamped_s;
    logic [4*DIGITS-1:0]   stepped_s;
    logic                  carry_out_s;
    logic [8*DIGITS-1:0]   seg_s;

    assign tick_s    = en && (presc_q == PRESC_LAST);
    assign dig_max_s = mode_dec ? DIG_MAX_DEC : DIG_MAX_HEX;

    // Clamp the held and load values, then ripple a +1/-1 through the digits.
    always_comb begin
        logic carry_v;
        carry_v        = 1'b1;
        clamped_s      = '0;
        load_clamped_s = '0;
        stepped_s      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            clamped_s[4*i +: 4]      = clamp_digit(count_q[4*i +: 4], mode_dec);
            load_clamped_s[4*i +: 4] = clamp_digit(load_val[4*i +: 4], mode_dec);
            if (!carry_v) begin
                stepped_s[4*i +: 4] = clamped_s[4*i +: 4];
            end else if (up) begin
                if (clamped_s[4*i +: 4] == dig_max_s) begin
                    stepped_s[4*i +: 4] = 4'd0;
                    carry_v             = 1'b1;
                end else begin
                    stepped_s[4*i +: 4] = clamped_s[4*i +: 4] + 4'd1;
                    carry_v             = 1'b0;
                end
            end else begin
                if (clamped_s[4*i +: 4] == 4'd0) begin
                    stepped_s[4*i +: 4] = dig_max_s;
                    carry_v             = 1'b1;
                end else begin
                    stepped_s[4*i +: 4] = clamped_s[4*i +: 4] - 4'd1;
                    carry_v             = 1'b0;
                end
            end
        end
        carry_out_s = carry_v;
    end

    // Next-state selection: load beats tick; an idle cycle still applies the clamp.
    always_comb begin
        presc_d = presc_q;
        count_d = clamped_s;
        wrap_d  = 1'b0;
        if (load) begin
            presc_d = '0;
            count_d = load_clamped_s;
        end else if (en) begin
            if (tick_s) begin
                presc_d = '0;
                count_d = stepped_s;
                wrap_d  = carry_out_s;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .nib_i (count_q[4*g +: 4]),
            .seg_o (seg_s[8*g +: 8])
        );
    end

    // Blank digits above the most significant non-zero one; digit 0 is always shown.
    always_comb begin
        logic seen_v;
        seen_v = 1'b0;
        hex_d  = {DIGITS{SEG_BLANK}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (count_q[4*i +: 4] != 4'd0) begin
                seen_v = 1'b1;
            end else begin
                seen_v = seen_v;
            end
            if (blank_lz && !seen_v && (i != 0)) begin
                hex_d[8*i +: 8] = SEG_BLANK;
            end else begin
                hex_d[8*i +: 8] = seg_s[8*i +: 8];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            hex_q   <= {DIGITS{SEG_BLANK}};
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            hex_q   <= hex_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign hex   = hex_q;

endmodule

// File: tb/tb_seg_counter_display.sv
// Directed and randomized bench for seg_counter_display (DIGITS=3, TICK_DIV=4)
// against an arithmetic reference model.
module tb_seg_counter_display;

    localparam int DIGITS   = 3;
    localparam int TICK_DIV = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 en;
    logic                 up;
    logic                 mode_dec;
    logic                 blank_lz;
    logic                 load;
    logic [4*DIGITS-1:0]  load_val;
    logic [4*DIGITS-1:0]  count;
    logic                 wrap;
    logic [8*DIGITS-1:0]  hex;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_cnt [DIGITS];
    int          m_presc;
    logic        m_wrap;
    logic [23:0] m_hex;

    seg_counter_display #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .up       (up),
        .mode_dec (mode_dec),
        .blank_lz (blank_lz),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .hex      (hex)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
           12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; 15: return 8'h8E;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [11:0] m_count();
        return 12'(m_cnt[2] * 256 + m_cnt[1] * 16 + m_cnt[0]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DIGITS; i++) m_cnt[i] = 0;
        m_presc = 0;
        m_wrap  = 1'b0;
        m_hex   = 24'hFFFFFF;
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_edge();
        int base, lim, v, d;
        int cl [DIGITS];
        logic [11:0] raw;
        logic        tick;
        if (!reset_n) begin
            model_reset();
            return;
        end
        raw = m_count();
        for (int i = 0; i < DIGITS; i++) begin
            if (blank_lz && i > 0 && (raw >> (4 * i)) == 12'd0) m_hex[8*i +: 8] = 8'hFF;
            else m_hex[8*i +: 8] = seg_of(m_cnt[i]);
        end
        base = mode_dec ? 10 : 16;
        lim  = base * base * base;
        for (int i = 0; i < DIGITS; i++) cl[i] = (mode_dec && m_cnt[i] > 9) ? 9 : m_cnt[i];
        tick   = en && (m_presc == TICK_DIV - 1);
        m_wrap = 1'b0;
        if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                d = int'(load_val[4*i +: 4]);
                m_cnt[i] = (mode_dec && d > 9) ? 9 : d;
            end
            m_presc = 0;
        end else begin
            if (en) m_presc = tick ? 0 : m_presc + 1;
            v = cl[0] + base * cl[1] + base * base * cl[2];
            if (tick) begin
                if (up) begin
                    v = v + 1;
                    if (v == lim) begin v = 0; m_wrap = 1'b1; end
                end else if (v == 0) begin
                    v = lim - 1; m_wrap = 1'b1;
                end else begin
                    v = v - 1;
                end
            end
            m_cnt[0] = v % base;
            m_cnt[1] = (v / base) % base;
            m_cnt[2] = v / (base * base);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("count", count, m_count());
        chk("wrap", wrap, m_wrap);
        chk("hex", hex, m_hex);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; en = 1'b0; up = 1'b1; mode_dec = 1'b0; blank_lz = 1'b0;
        load = 1'b0; load_val = '0;
        model_reset();
        #12;
        chk("rst_count", count, 12'h000);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_hex", hex, 24'hFFFFFF);

        // First count after 4 cycles, then blanking of leading zeros.
        @(negedge clk); reset_n = 1'b1; en = 1'b1;
        repeat (4) cycle();
        chk("first_tick_count", count, 12'h001);
        cycle();
        chk("first_hex", hex, 24'hC0C0F9);
        blank_lz = 1'b1;
        cycle();
        chk("blank_hex", hex, 24'hFFFFF9);

        // Decimal carry across two digits.
        blank_lz = 1'b0; mode_dec = 1'b1; load = 1'b1; load_val = 12'h099;
        cycle();
        load = 1'b0;
        repeat (4) cycle();
        chk("dec_carry_count", count, 12'h100);
        cycle();
        chk("dec_carry_hex", hex, 24'hF9C0C0);

        // Decimal wrap up then wrap down.
        load = 1'b1; load_val = 12'h999;
        cycle();
        load = 1'b0;
        repeat (4) cycle();
        chk("wrap_up_count", count, 12'h000);
        chk("wrap_up_pulse", wrap, 1'b1);
        cycle();
        chk("wrap_up_clear", wrap, 1'b0);
        up = 1'b0;
        repeat (3) cycle();
        chk("wrap_dn_count", count, 12'h999);
        chk("wrap_dn_pulse", wrap, 1'b1);

        // Switching to decimal clamps a hex value without a wrap.
        up = 1'b1; en = 1'b0; mode_dec = 1'b0; load = 1'b1; load_val = 12'hFFF;
        cycle();
        chk("hex_load", count, 12'hFFF);
        load = 1'b0; mode_dec = 1'b1;
        cycle();
        chk("clamp_count", count, 12'h999);
        chk("clamp_wrap", wrap, 1'b0);

        // Load in the same cycle as a tick wins and restarts the prescaler.
        mode_dec = 1'b0; en = 1'b1;
        for (int k = 0; k < 8 && m_presc != TICK_DIV - 1; k++) cycle();
        load = 1'b1; load_val = 12'h123;
        cycle();
        chk("load_tick_count", count, 12'h123);
        chk("load_tick_wrap", wrap, 1'b0);
        load = 1'b0;
        repeat (3) cycle();
        chk("load_hold_count", count, 12'h123);
        cycle();
        chk("load_next_tick", count, 12'h124);

        // Asynchronous reset in the middle of counting.
        repeat (6) cycle();
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_count", count, 12'h000);
        chk("async_rst_hex", hex, 24'hFFFFFF);
        chk("async_rst_wrap", wrap, 1'b0);
        model_reset();
        cycle();
        @(negedge clk); reset_n = 1'b1;
        repeat (4) cycle();
        chk("resume_count", count, 12'h001);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) up = ~up;
            if ($urandom_range(0, 31) == 0) mode_dec = ~mode_dec;
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            load     = ($urandom_range(0, 24) == 0);
            load_val = 12'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                cycle();
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
